// File: rtl/uart_response_tx_pkg.sv
// Shared command codes, framing bytes and state/job encodings for the UART response path.
package uart_response_tx_pkg;

  localparam logic [7:0] CMD_DIGIT_READ  = 8'hCC;
  localparam logic [7:0] CMD_SCORES_READ = 8'hCD;
  localparam logic [7:0] SCORES_START1   = 8'hEE;
  localparam logic [7:0] SCORES_START2   = 8'h77;
  localparam logic [7:0] SCORES_END1     = 8'h77;
  localparam logic [7:0] SCORES_END2     = 8'hEE;
  localparam logic [7:0] NAK             = 8'hFF;

  localparam int NUM_CLASSES_DEF  = 10;
  localparam int SCORE_W_DEF      = 32;
  localparam int SCORES_FRAME_LEN = 4 + NUM_CLASSES_DEF * SCORE_W_DEF / 8;

  // Two start markers, the little-endian score bytes, two end markers.
  function automatic int frame_len(input int num_classes, input int score_w);
    return 4 + num_classes * score_w / 8;
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_e;
  typedef enum logic {JOB_DIGIT, JOB_SCORES} job_e;

endpackage

// File: rtl/uart_response_tx_tx.sv
// 8N1 bit serialiser, LSB first; start is taken only when idle and the start bit appears the next cycle.
// done pulses in the final cycle of the stop bit so a following byte can start right behind it.
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic             tick;

  assign tick = busy_q && (baud_q == BIT_LAST);
  assign done = tick && (bit_q == 4'd9);
  assign tx   = tx_q;
  assign busy = busy_q;

  always_comb begin
    tx_d    = tx_q;
    busy_d  = busy_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    if (!busy_q) begin
      if (start) begin
        busy_d  = 1'b1;
        tx_d    = 1'b0;
        shift_d = {1'b1, data};
        bit_d   = 4'd0;
        baud_d  = '0;
      end
    end else if (tick) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
      end else begin
        // shift_q[8] is the stop bit; ones backfill so the line stays high after it.
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      shift_q <= '1;
      bit_q   <= 4'd0;
      baud_q  <= '0;
    end else begin
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
    end
  end

endmodule

// File: rtl/uart_response_tx.sv
// Command FSM, one-deep pending slot and response byte mux driving the UART TX line.
// First start bit two cycles after acceptance; commands beyond the pending slot are dropped and counted.
module uart_response_tx #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   cmd_rx_data,
  input  logic                         cmd_rx_ready,
  input  logic                         result_valid,
  input  logic [3:0]                   predicted_digit,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
  output logic                         tx,
  output logic                         busy,
  output logic [7:0]                   drop_count
);
  import uart_response_tx_pkg::*;

  localparam int FRAME_LEN = frame_len(NUM_CLASSES, SCORE_W);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] FRAME_END1 = IDX_W'(FRAME_LEN - 2);

  state_e                       state_q, state_d;
  job_e                         job_q, job_d, pend_job_q, pend_job_d, cmd_job;
  logic                         pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]             idx_q, idx_d, last_idx, sidx;
  logic [3:0]                   digit_q, digit_d;
  logic [NUM_CLASSES*SCORE_W-1:0] scores_q, scores_d;
  logic                         valid_q, valid_d;
  logic                         busy_q, busy_d;
  logic [7:0]                   drop_q, drop_d;
  logic                         is_cmd, take_cmd;
  logic [7:0]                   tx_byte;
  logic                         ser_start, ser_busy, ser_done;

  assign is_cmd   = cmd_rx_ready &&
                    (cmd_rx_data == CMD_DIGIT_READ || cmd_rx_data == CMD_SCORES_READ);
  assign cmd_job  = (cmd_rx_data == CMD_SCORES_READ) ? JOB_SCORES : JOB_DIGIT;
  assign last_idx = (job_q == JOB_SCORES && valid_q) ? FRAME_LAST : '0;
  assign sidx     = idx_q - IDX_W'(2);
  assign ser_start = (state_q == SEND);

  always_comb begin
    state_d    = state_q;
    job_d      = job_q;
    pend_vld_d = pend_vld_q;
    pend_job_d = pend_job_q;
    idx_d      = idx_q;
    digit_d    = digit_q;
    scores_d   = scores_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    take_cmd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          job_d      = pend_job_q;
          pend_vld_d = 1'b0;
          state_d    = LOAD;
        end else if (is_cmd) begin
          job_d    = cmd_job;
          take_cmd = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        digit_d  = predicted_digit;
        scores_d = scores;
        valid_d  = result_valid;
        idx_d    = '0;
        state_d  = SEND;
      end
      SEND: if (!ser_busy) state_d = WAIT;
      WAIT: begin
        if (ser_done) begin
          if (idx_q == last_idx) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A slot freed by IDLE this cycle can take the new command straight away.
    if (is_cmd && !take_cmd) begin
      if (!pend_vld_d) begin
        pend_vld_d = 1'b1;
        pend_job_d = cmd_job;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
    busy_d = (state_d != IDLE) || pend_vld_d;
  end

  always_comb begin
    tx_byte = NAK;
    if (job_q == JOB_DIGIT) begin
      if (valid_q) tx_byte = {4'h0, digit_q};
    end else if (valid_q) begin
      if (idx_q == '0)                 tx_byte = SCORES_START1;
      else if (idx_q == IDX_W'(1))     tx_byte = SCORES_START2;
      else if (idx_q == FRAME_END1)    tx_byte = SCORES_END1;
      else if (idx_q == FRAME_LAST)    tx_byte = SCORES_END2;
      else                             tx_byte = scores_q[{sidx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      job_q      <= JOB_DIGIT;
      pend_vld_q <= 1'b0;
      pend_job_q <= JOB_DIGIT;
      idx_q      <= '0;
      digit_q    <= 4'd0;
      scores_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      job_q      <= job_d;
      pend_vld_q <= pend_vld_d;
      pend_job_q <= pend_job_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      scores_q   <= scores_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (tx_byte),
    .start (ser_start),
    .tx    (tx),
    .busy  (ser_busy),
    .done  (ser_done)
  );

  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_response_tx.sv
// Directed bench for uart_response_tx: line-level 8N1 decoder plus vector table and corner sequences.
module tb_uart_response_tx;

  localparam int BIT      = 16;
  localparam int BAUD     = 115200;
  localparam int CLK_FREQ = BAUD * BIT;
  localparam int NC       = 10;
  localparam int SW       = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       cmd_rx_data = 8'h00;
  logic             cmd_rx_ready = 1'b0;
  logic             result_valid = 1'b0;
  logic [3:0]       predicted_digit = 4'd0;
  logic [NC*SW-1:0] scores = '0;
  logic             tx, busy;
  logic [7:0]       drop_count;

  uart_response_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .NUM_CLASSES(NC), .SCORE_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .cmd_rx_data(cmd_rx_data), .cmd_rx_ready(cmd_rx_ready),
    .result_valid(result_valid), .predicted_digit(predicted_digit), .scores(scores),
    .tx(tx), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  // Line decoder: samples mid-bit, records start cycle and decoded byte.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         mon_cnt = 0;
  int         mon_ferr = 0;
  bit         mon_act = 1'b0;
  logic [7:0] mon_sh = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
        rx_t.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 9 * BIT + BIT / 2) begin
        if (tx !== 1'b1) mon_ferr++;
        rx_q.push_back(mon_sh);
        mon_act = 1'b0;
      end else if (mon_cnt % BIT == BIT / 2) begin
        mon_sh = {tx, mon_sh[7:1]};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_rx_data  = c;
    cmd_rx_ready = 1'b1;
    @(negedge clk);
    cmd_rx_ready = 1'b0;
    cmd_rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      checks++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic wait_bytes(input int k, input int budget);
    int t = 0;
    while (rx_q.size() < k && t < budget) begin
      t++;
      @(negedge clk);
    end
    if (rx_q.size() < k) begin
      checks++;
      $display("FAIL wait_bytes: got %0d bytes, required %0d", rx_q.size(), k);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       rv;
    logic [3:0] dig;
    int         nbytes;
    logic [7:0] b0;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_a[45];
  logic [NC*SW-1:0] scores_a;

  initial begin
    int n, t_acc, gmax, g;
    bit seen;
    logic [7:0] got;

    vecs[0] = '{8'hCC, 1'b1, 4'd7, 1, 8'h07};
    vecs[1] = '{8'hCC, 1'b1, 4'd0, 1, 8'h00};
    vecs[2] = '{8'hCC, 1'b1, 4'd9, 1, 8'h09};
    vecs[3] = '{8'hCC, 1'b0, 4'd7, 1, 8'hFF};
    vecs[4] = '{8'hCD, 1'b0, 4'd3, 1, 8'hFF};
    vecs[5] = '{8'h12, 1'b1, 4'd7, 0, 8'h00};
    vecs[6] = '{8'hCE, 1'b1, 4'd7, 0, 8'h00};

    scores_a = '0;
    scores_a[31:0]        = 32'h11223344;
    scores_a[9*SW +: SW]  = 32'hFFFFFF80;
    for (int i = 0; i < 45; i++) exp_a[i] = 8'h00;
    exp_a[0] = 8'hEE; exp_a[1] = 8'h77;
    exp_a[2] = 8'h44; exp_a[3] = 8'h33; exp_a[4] = 8'h22; exp_a[5] = 8'h11;
    exp_a[38] = 8'h80; exp_a[39] = 8'hFF; exp_a[40] = 8'hFF; exp_a[41] = 8'hFF;
    exp_a[42] = 8'h77; exp_a[43] = 8'hEE;
    exp_a[44] = 8'h05;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_drop", drop_count, 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      result_valid    = vecs[i].rv;
      predicted_digit = vecs[i].dig;
      clear_rx();
      send_cmd(vecs[i].cmd);
      t_acc = cyc;
      if (vecs[i].nbytes > 0) begin
        wait_idle(40 * BIT, n);
        check_range($sformatf("busy_len[%0d]", i), n, 10 * BIT - 2, 10 * BIT + 2);
      end else begin
        seen = 1'b0;
        repeat (30) begin
          if (busy) seen = 1'b1;
          @(negedge clk);
        end
        check($sformatf("ignored_busy[%0d]", i), seen, 1'b0);
      end
      repeat (4) @(negedge clk);
      check($sformatf("nbytes[%0d]", i), rx_q.size(), vecs[i].nbytes);
      if (vecs[i].nbytes > 0 && rx_q.size() > 0) begin
        check($sformatf("byte[%0d]", i), rx_q[0], vecs[i].b0);
        check_range($sformatf("latency[%0d]", i), rx_t[0] - t_acc, 1, 3);
      end
    end

    // Scores frame with two digit requests and input changes mid-frame.
    result_valid = 1'b1;
    predicted_digit = 4'd3;
    scores = scores_a;
    clear_rx();
    send_cmd(8'hCD);
    wait_bytes(3, 5 * 10 * BIT);
    send_cmd(8'hCC);
    send_cmd(8'hCC);
    predicted_digit = 4'd5;
    scores = {NC{32'hA5A5A5A5}};
    wait_idle(50 * 10 * BIT, n);
    repeat (4) @(negedge clk);
    check("frame_len", rx_q.size(), 45);
    for (int i = 0; i < 45; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check($sformatf("frame[%0d]", i), got, exp_a[i]);
    end
    gmax = -1;
    if (rx_t.size() >= 45) begin
      gmax = 0;
      for (int i = 1; i < 44; i++) begin
        g = rx_t[i] - rx_t[i-1];
        if (g > gmax) gmax = g;
      end
      check_range("pend_gap", rx_t[44] - rx_t[43], 10 * BIT, 11 * BIT);
    end
    check_range("frame_gap", gmax, 10 * BIT, 10 * BIT + 2);
    check("drop_after_frame", drop_count, 8'd1);

    // Digit snapshot: inputs change while the byte is on the line.
    result_valid = 1'b1;
    predicted_digit = 4'd7;
    clear_rx();
    send_cmd(8'hCC);
    repeat (30) @(negedge clk);
    predicted_digit = 4'd2;
    result_valid = 1'b0;
    wait_idle(40 * BIT, n);
    repeat (4) @(negedge clk);
    check("snap_nbytes", rx_q.size(), 1);
    check("snap_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h07);

    // Drop saturation, then reset in the middle of the 20th byte.
    result_valid = 1'b1;
    scores = scores_a;
    clear_rx();
    send_cmd(8'hCD);
    for (int i = 0; i < 300; i++) send_cmd(8'hCC);
    check("drop_saturate", drop_count, 8'hFF);
    wait_bytes(19, 30 * 10 * BIT);
    repeat (5 * BIT) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("midbyte_rst_tx", tx, 1'b1);
    check("midbyte_rst_busy", busy, 1'b0);
    check("midbyte_rst_drop", drop_count, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_rx();
    repeat (30 * BIT) @(negedge clk);
    check("post_rst_nbytes", rx_q.size(), 0);
    check("post_rst_busy", busy, 1'b0);
    predicted_digit = 4'd4;
    send_cmd(8'hCC);
    wait_idle(40 * BIT, n);
    repeat (4) @(negedge clk);
    check("post_rst_cmd_nbytes", rx_q.size(), 1);
    check("post_rst_cmd_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h04);
    check("framing_errors", mon_ferr, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
